mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage of the MINAv2 five-stage pipeline. Sits between the EX/MEM register and MEM/WB; consumes mem_params_t produced by the execute stage.
- Performs loads and stores over a single-outstanding request/acknowledge data bus. Stalls upstream stages while an access is pending.
- Contains the MEM/WB pipeline register. Its registered output also feeds the MEM/WB forwarding path into execute (rd_data_mem_wb).

Parameters:
- BUS_TIMEOUT, 0, cycles to wait for dbus_ack before aborting. 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  EX/MEM holds a valid instruction
- mem_params  in  mem_params_t  rd_addr, rd_data (ALU result = address for memory ops), mem_op, mem_data (store data)
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM this cycle
- dbus_req  out  1  bus request (registered)
- dbus_we  out  1  1 = store
- dbus_addr  out  32  word-aligned address, bits [1:0] = 0
- dbus_be  out  4  byte enables, little-endian
- dbus_wdata  out  32  store data, lane-replicated
- dbus_ack  in  1  access complete; dbus_rdata valid this cycle
- dbus_rdata  in  32  load data word
- wb_valid  out  1  MEM/WB holds a valid instruction
- wb_params  out  wb_params_t  rd_addr, rd_data to writeback; rd_data is also rd_data_mem_wb for forwarding
- fault  out  1  one-cycle pulse on misaligned access or bus timeout
- fault_addr  out  32  offending address, held until next fault

Behaviour:
- Reset values: state IDLE; dbus_req=0, dbus_we=0, dbus_addr=0, dbus_be=0, dbus_wdata=0; wb_valid=0, wb_params=0; fault=0, fault_addr=0. Reset wins over all other events. A rst while BUSY abandons the access: dbus_req is 0 the cycle after; any later ack in IDLE is ignored.
- mem_op encodings: MEM_OP_NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
- Non-memory op (MEM_OP_NONE, in_valid=1): next edge loads wb_valid=1 and wb_params={rd_addr, rd_data}. Latency 1, stall=0.
- in_valid=0 in IDLE: next edge loads wb_valid=0 (bubble); wb_params is don't-care but holds its previous value.
- FSM has two states, IDLE and BUSY.
- IDLE, in_valid and memory op:
  - stall=1 (combinational).
  - Latch addr, be, wdata, op and rd_addr.
  - Next edge: dbus_req=1, state BUSY, wb_valid=0.
- BUSY:
  - dbus_req and all dbus_* outputs held stable. stall = !dbus_ack.
  - On ack: dbus_req=0 and state IDLE at the next edge.
  - On ack, load: MEM/WB loads wb_valid=1, rd_data = extracted and extended data.
  - On ack, store: wb_valid=1, rd_data=0. The decoder guarantees rd_addr=0 for stores.
- Stall release: stall deasserts in the ack cycle, so EX/MEM advances at the same edge. The next memory op may start in the cycle after ack. Minimum memory-op latency is 2 cycles (request cycle plus ack cycle).
- Byte enables:
  - Byte ops: be = 1 << addr[1:0].
  - Halfword ops: be = addr[1] ? 1100 : 0011.
  - Word ops: be = 1111.
- Store data lanes: SB replicates mem_data[7:0] ×4; SH replicates mem_data[15:0] ×2; SW passes through.
- Load extract: data = dbus_rdata >> (8·byte offset). LB/LH sign-extend; LBU/LHU zero-extend.
- Timeout (BUS_TIMEOUT > 0):
  - A counter starts at request. After BUS_TIMEOUT cycles without ack: dbus_req drops, fault pulses, fault_addr = address, wb_valid=0, stall releases, state returns to IDLE.
  - An ack arriving in the same cycle as expiry takes priority.
- rd_addr=0 is passed through unchanged; r0 writes are discarded by the register file.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- A halfword op is misaligned when addr[0]=1; a word op when addr[1:0]≠0.
- Defined: a misaligned op issues no bus request. Next edge: fault=1 for one cycle, fault_addr = address, wb_valid=0 (write suppressed). stall=0.
- Undefined: misaligned low address bits are ignored. Halfword treats addr[0] as 0; word treats addr[1:0] as 00. No fault is raised from misalignment; fault stays tied to the timeout path only.

Decomposition:
- types package:
  - Extend mem_op_e with the LB…SW encodings.
  - Add wb_params_t {rd_addr, rd_data}.
  - Add mem_state_e {MEM_IDLE, MEM_BUSY}.
- Sub-module mem_align: combinational. Takes op and addr[1:0]; produces dbus_be, replicated wdata and load-extracted/extended data. Unit-testable on its own.

Test Plan:
- ALU op through: in_valid=1, NONE, rd_addr=5, rd_data=0x1234 -> next cycle wb_valid=1, wb={5, 0x1234}, stall never 1.
- LB: addr=0x103, ack after 3 cycles, rdata=0x80FF_FF00 -> dbus_addr=0x100, be=1000, stall high 4 cycles, wb rd_data=0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- SH: addr=0x202, mem_data=0xDEAD_BEEF, immediate ack -> dbus_we=1, be=1100, wdata=0xBEEF_BEEF, wb_valid=1 next edge.
- Back-to-back LW then SW: the second dbus_req rises one cycle after the first ack; no bubble beyond the single-cycle request gap.
- rst asserted while BUSY -> dbus_req=0 and wb_valid=0 the next cycle; a late ack causes no wb_valid.
- Misalignment, LW addr=0x102:
  - With MEM_MISALIGN_TRAP_EN: no dbus_req, fault pulse, fault_addr=0x102, wb_valid=0.
  - Without it: dbus_addr=0x100, be=1111.
  - With BUS_TIMEOUT=4 and no ack: fault after 4 cycles.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Types shared by the MINAv2 memory stage: memory op encodings, EX/MEM and
// MEM/WB payloads, FSM states and small op-classification helpers.
package mem_stage_pkg;

  typedef enum logic [3:0] {
    MEM_OP_NONE, MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU,
    MEM_OP_LW, MEM_OP_SB, MEM_OP_SH, MEM_OP_SW
  } mem_op_e;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    mem_op_e     mem_op;
    logic [31:0] mem_data;
  } mem_params_t;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
  } wb_params_t;

  typedef enum logic {MEM_IDLE, MEM_BUSY} mem_state_e;

  function automatic logic is_mem(input mem_op_e op);
    return op != MEM_OP_NONE;
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return op inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW};
  endfunction

  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] lo);
    case (op)
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return lo[0];
      MEM_OP_LW, MEM_OP_SW:             return lo != 2'b00;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// mem_align: combinational lane logic for the memory stage. Byte enables,
// store-data replication and load extraction/extension from op and addr[1:0].
module mem_align
  import mem_stage_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [1:0]  off;
  logic [31:0] shifted;

  always_comb begin
    // Sub-size offset bits are dropped so misaligned halfword/word ops act aligned.
    off = 2'b00;
    be  = 4'b0000;
    case (op)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: begin
        off = addr_lo;
        be  = 4'b0001 << addr_lo;
      end
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: begin
        off = {addr_lo[1], 1'b0};
        be  = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      MEM_OP_LW, MEM_OP_SW: be = 4'b1111;
      default: ;
    endcase

    shifted = load_word >> {off, 3'b000};

    case (op)
      MEM_OP_SB: wdata = {4{store_data[7:0]}};
      MEM_OP_SH: wdata = {2{store_data[15:0]}};
      default:   wdata = store_data;
    endcase

    case (op)
      MEM_OP_LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      MEM_OP_LBU: load_data = {24'h0, shifted[7:0]};
      MEM_OP_LH:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      MEM_OP_LHU: load_data = {16'h0, shifted[15:0]};
      default:    load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MINAv2 memory stage with MEM/WB register, single-outstanding data bus and
// optional bus timeout. MEM_MISALIGN_TRAP_EN turns misaligned ops into faults.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  mem_params_t mem_params,
  output logic        stall,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        wb_valid,
  output wb_params_t  wb_params,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam int unsigned CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BUS_TIMEOUT - 1);
  localparam bit TO_EN = (BUS_TIMEOUT != 0);

  mem_state_e  state_q, state_d;
  logic        req_q, req_d, we_q, we_d, wb_valid_q, wb_valid_d, fault_q, fault_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, raw_q, raw_d, fault_addr_q, fault_addr_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  mem_op_e     op_q, op_d, align_op;
  wb_params_t  wb_q, wb_d;
  logic [1:0]  align_off;
  logic [3:0]  align_be;
  logic [31:0] align_wdata, align_load;
  logic        trap;

  // One align instance: encodes the incoming request in IDLE, decodes rdata in BUSY.
  assign align_op  = (state_q == MEM_BUSY) ? op_q  : mem_params.mem_op;
  assign align_off = (state_q == MEM_BUSY) ? off_q : mem_params.rd_data[1:0];

  mem_align u_align (
    .op(align_op), .addr_lo(align_off), .store_data(mem_params.mem_data),
    .load_word(dbus_rdata), .be(align_be), .wdata(align_wdata), .load_data(align_load)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = is_misaligned(mem_params.mem_op, mem_params.rd_data[1:0]);
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d = state_q;  req_d = req_q;      we_d = we_q;        addr_d = addr_q;
    be_d = be_q;        wdata_d = wdata_q;  op_d = op_q;        off_d = off_q;
    rd_addr_d = rd_addr_q; raw_d = raw_q;   cnt_d = cnt_q;
    wb_valid_d = 1'b0;  wb_d = wb_q;        fault_d = 1'b0;     fault_addr_d = fault_addr_q;
    stall = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (in_valid && !is_mem(mem_params.mem_op)) begin
          wb_valid_d = 1'b1;
          wb_d = '{rd_addr: mem_params.rd_addr, rd_data: mem_params.rd_data};
        end else if (in_valid && trap) begin
          fault_d      = 1'b1;
          fault_addr_d = mem_params.rd_data;
        end else if (in_valid) begin
          stall     = 1'b1;
          state_d   = MEM_BUSY;
          req_d     = 1'b1;
          we_d      = is_store(mem_params.mem_op);
          addr_d    = {mem_params.rd_data[31:2], 2'b00};
          be_d      = align_be;
          wdata_d   = align_wdata;
          op_d      = mem_params.mem_op;
          off_d     = mem_params.rd_data[1:0];
          raw_d     = mem_params.rd_data;
          rd_addr_d = mem_params.rd_addr;
          cnt_d     = '0;
        end
      end
      MEM_BUSY: begin
        stall = !dbus_ack;
        cnt_d = cnt_q + 1'b1;
        if (dbus_ack) begin
          state_d    = MEM_IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_d = '{rd_addr: rd_addr_q, rd_data: is_store(op_q) ? 32'h0 : align_load};
        end else if (TO_EN && cnt_q == CNT_LAST) begin
          state_d      = MEM_IDLE;
          req_d        = 1'b0;
          stall        = 1'b0;
          fault_d      = 1'b1;
          fault_addr_d = raw_q;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEM_IDLE;  req_q <= 1'b0;  we_q <= 1'b0;  addr_q <= '0;
      be_q <= '0;  wdata_q <= '0;  op_q <= MEM_OP_NONE;  off_q <= '0;
      rd_addr_q <= '0;  raw_q <= '0;  cnt_q <= '0;
      wb_valid_q <= 1'b0;  wb_q <= '0;  fault_q <= 1'b0;  fault_addr_q <= '0;
    end else begin
      state_q <= state_d;  req_q <= req_d;  we_q <= we_d;  addr_q <= addr_d;
      be_q <= be_d;  wdata_q <= wdata_d;  op_q <= op_d;  off_q <= off_d;
      rd_addr_q <= rd_addr_d;  raw_q <= raw_d;  cnt_q <= cnt_d;
      wb_valid_q <= wb_valid_d;  wb_q <= wb_d;  fault_q <= fault_d;  fault_addr_q <= fault_addr_d;
    end
  end

  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_be    = be_q;
  assign dbus_wdata = wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_params  = wb_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;

endmodule
